// File: rtl/smiley_game_controller_if.sv
// Mover-side bus of the smiley game controller: position/collision in,
// tick, restart, bounce and deduplicated collision out.
interface smiley_game_controller_if;
  logic               collision;
  logic [3:0]         HitEdgeCode;
  logic signed [10:0] topLeftY;
  logic               moverTick;
  logic               moverRestartN;
  logic               toggleY;
  logic               collisionOut;
  logic [3:0]         hitEdgeOut;

  modport master (
    input  collision, HitEdgeCode, topLeftY,
    output moverTick, moverRestartN, toggleY, collisionOut, hitEdgeOut
  );

  modport slave (
    output collision, HitEdgeCode, topLeftY,
    input  moverTick, moverRestartN, toggleY, collisionOut, hitEdgeOut
  );
endinterface

// File: rtl/smiley_game_controller.sv
// Game sequencer for the bouncing smiley: state machine, lives, mover tick
// gating, ceiling-bounce request and per-frame collision deduplication.
module smiley_game_controller #(
  parameter int NUM_LIVES    = 3,
  parameter int SERVE_FRAMES = 30,
  parameter int LOST_FRAMES  = 60,
  parameter int FLOOR_Y      = 440,
  parameter int CEIL_Y       = 16
) (
  input  logic                             clk,
  input  logic                             resetN,
  input  logic                             startOfFrame,
  input  logic                             startKey,
  input  logic                             pauseKey,
  smiley_game_controller_if.master         bus,
  output logic [2:0]                       lives,
  output logic                             gameOver,
  output logic [2:0]                       state
);

  localparam int MAX_FRAMES = (SERVE_FRAMES > LOST_FRAMES) ? SERVE_FRAMES : LOST_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES) + 1;
  localparam logic [CNT_W-1:0]  SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]  LOST_LAST  = CNT_W'(LOST_FRAMES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [2:0]        LIVES_INIT = 3'(NUM_LIVES);
  localparam logic signed [10:0] FLOOR_S   = 11'(FLOOR_Y);
  localparam logic signed [10:0] CEIL_S    = 11'(CEIL_Y);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_LOST  = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  state_t           state_r, next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic [2:0]       lives_r, lives_next_s;
  logic             start_prev_r, pause_prev_r;
  logic             armed_r, reported_r;
  logic             tick_r, restart_n_r, toggle_r, coll_r, game_over_r;
  logic [3:0]       hit_r;

  logic start_rise_s, pause_rise_s, floor_s, ceil_s, report_s;

  assign start_rise_s = startKey & ~start_prev_r;
  assign pause_rise_s = pauseKey & ~pause_prev_r;
  assign floor_s      = (bus.topLeftY >= FLOOR_S);
  assign ceil_s       = (bus.topLeftY <= CEIL_S);
  // A start-of-frame clears the flag in the same cycle, so that collision still counts.
  assign report_s     = (state_r == S_PLAY) & bus.collision & (startOfFrame | ~reported_r);

  // Next-state, frame counter and lives computation.
  always_comb begin
    next_s       = state_r;
    cnt_next_s   = cnt_r;
    lives_next_s = lives_r;
    case (state_r)
      S_IDLE, S_OVER: begin
        if (start_rise_s) begin
          next_s       = S_SERVE;
          lives_next_s = LIVES_INIT;
          cnt_next_s   = '0;
        end else begin
          next_s = state_r;
        end
      end
      S_SERVE: begin
        if (startOfFrame && (cnt_r == SERVE_LAST)) begin
          next_s     = S_PLAY;
          cnt_next_s = '0;
        end else if (startOfFrame) begin
          cnt_next_s = cnt_r + CNT_ONE;
        end else begin
          cnt_next_s = cnt_r;
        end
      end
      S_PLAY: begin
        // Losing the ball outranks a simultaneous pause request.
        if (floor_s) begin
          next_s       = S_LOST;
          cnt_next_s   = '0;
          lives_next_s = (lives_r != 3'd0) ? (lives_r - 3'd1) : lives_r;
        end else if (pause_rise_s) begin
          next_s = S_PAUSE;
        end else begin
          next_s = state_r;
        end
      end
      S_PAUSE: begin
        if (pause_rise_s) begin
          next_s = S_PLAY;
        end else begin
          next_s = state_r;
        end
      end
      S_LOST: begin
        if (startOfFrame && (cnt_r == LOST_LAST)) begin
          next_s     = (lives_r != 3'd0) ? S_SERVE : S_OVER;
          cnt_next_s = '0;
        end else if (startOfFrame) begin
          cnt_next_s = cnt_r + CNT_ONE;
        end else begin
          cnt_next_s = cnt_r;
        end
      end
      default: begin
        next_s     = S_IDLE;
        cnt_next_s = '0;
      end
    endcase
  end

  // State, counters, edge detectors and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r      <= S_IDLE;
      cnt_r        <= '0;
      lives_r      <= LIVES_INIT;
      start_prev_r <= 1'b0;
      pause_prev_r <= 1'b0;
      armed_r      <= 1'b1;
      reported_r   <= 1'b0;
      tick_r       <= 1'b0;
      restart_n_r  <= 1'b0;
      toggle_r     <= 1'b0;
      coll_r       <= 1'b0;
      hit_r        <= 4'd0;
      game_over_r  <= 1'b0;
    end else begin
      state_r      <= next_s;
      cnt_r        <= cnt_next_s;
      lives_r      <= lives_next_s;
      start_prev_r <= startKey;
      pause_prev_r <= pauseKey;
      tick_r       <= startOfFrame & (state_r == S_PLAY) & (next_s == S_PLAY);
      restart_n_r  <= (next_s == S_PLAY) | (next_s == S_PAUSE) | (next_s == S_LOST);
      game_over_r  <= (next_s == S_OVER);
      toggle_r     <= (state_r == S_PLAY) & ceil_s & armed_r;
      armed_r      <= !ceil_s ? 1'b1 : ((state_r == S_PLAY) ? 1'b0 : armed_r);
      reported_r   <= report_s ? 1'b1 : (startOfFrame ? 1'b0 : reported_r);
      coll_r       <= report_s;
      hit_r        <= report_s ? bus.HitEdgeCode : hit_r;
    end
  end

  assign bus.moverTick     = tick_r;
  assign bus.moverRestartN = restart_n_r;
  assign bus.toggleY       = toggle_r;
  assign bus.collisionOut  = coll_r;
  assign bus.hitEdgeOut    = hit_r;
  assign lives             = lives_r;
  assign gameOver          = game_over_r;
  assign state             = state_r;

endmodule

// File: tb/tb_smiley_game_controller.sv
// Directed bench for smiley_game_controller: walks serve, play, collisions,
// ceiling bounces, pause, life loss, game over and asynchronous reset.
module tb_smiley_game_controller;
  logic clk = 1'b0;
  logic resetN, startOfFrame, startKey, pauseKey;
  logic [2:0] lives, state;
  logic gameOver;
  int errors = 0;
  int checks = 0;
  int tick_seen = 0, coll_seen = 0, tog_seen = 0;
  int t0, c0;

  smiley_game_controller_if bus();

  smiley_game_controller dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .startKey(startKey), .pauseKey(pauseKey), .bus(bus),
    .lives(lives), .gameOver(gameOver), .state(state)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the inactive edge.
  always @(negedge clk) begin
    if (bus.moverTick)    tick_seen <= tick_seen + 1;
    if (bus.collisionOut) coll_seen <= coll_seen + 1;
    if (bus.toggleY)      tog_seen  <= tog_seen + 1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      cyc();
      startOfFrame = 1'b0;
      repeat (7) cyc();
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0; startOfFrame = 1'b0; startKey = 1'b0; pauseKey = 1'b0;
    bus.collision = 1'b0; bus.HitEdgeCode = 4'd0; bus.topLeftY = 11'sd100;
    #23;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (lives !== 3'd3) begin errors++; $display("FAIL reset_lives: got %0d expected 3", lives); end
    checks++; if ({gameOver, bus.moverTick, bus.moverRestartN, bus.toggleY, bus.collisionOut, bus.hitEdgeOut} !== 9'd0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 000000000",
        {gameOver, bus.moverTick, bus.moverRestartN, bus.toggleY, bus.collisionOut, bus.hitEdgeOut});
    end
    cyc();
    resetN = 1'b1;
    cyc();
  endtask

  task automatic test_serve();
    startKey = 1'b1; cyc();
    checks++; if (state !== 3'd1 || bus.moverRestartN !== 1'b0) begin errors++; $display("FAIL serve_entry: got state=%0d rst=%b expected 1/0", state, bus.moverRestartN); end
    frame(29);
    startKey = 1'b0;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL serve_29: got %0d expected 1", state); end
    frame(1);
    checks++; if (state !== 3'd2 || bus.moverRestartN !== 1'b1) begin errors++; $display("FAIL serve_to_play: got state=%0d rst=%b expected 2/1", state, bus.moverRestartN); end
    startOfFrame = 1'b1; cyc(); startOfFrame = 1'b0;
    checks++; if (bus.moverTick !== 1'b1) begin errors++; $display("FAIL tick_follow: got %b expected 1", bus.moverTick); end
    cyc();
    checks++; if (bus.moverTick !== 1'b0) begin errors++; $display("FAIL tick_drop: got %b expected 0", bus.moverTick); end
    repeat (6) cyc();
  endtask

  task automatic test_collision();
    c0 = coll_seen;
    bus.collision = 1'b1; bus.HitEdgeCode = 4'b0100;
    repeat (200) cyc();
    bus.collision = 1'b0; bus.HitEdgeCode = 4'b0000; cyc(); cyc();
    checks++; if (coll_seen - c0 !== 1 || bus.hitEdgeOut !== 4'b0100) begin errors++; $display("FAIL coll_frame1: got n=%0d edge=%b expected 1/0100", coll_seen - c0, bus.hitEdgeOut); end
    frame(1);
    bus.collision = 1'b1; bus.HitEdgeCode = 4'b0010;
    repeat (3) cyc();
    bus.collision = 1'b0; bus.HitEdgeCode = 4'b0000; cyc(); cyc();
    checks++; if (coll_seen - c0 !== 2 || bus.hitEdgeOut !== 4'b0010) begin errors++; $display("FAIL coll_frame2: got n=%0d edge=%b expected 2/0010", coll_seen - c0, bus.hitEdgeOut); end
    startOfFrame = 1'b1; bus.collision = 1'b1; bus.HitEdgeCode = 4'b1000; cyc();
    startOfFrame = 1'b0; bus.collision = 1'b0; bus.HitEdgeCode = 4'b0000; repeat (7) cyc();
    checks++; if (coll_seen - c0 !== 3 || bus.hitEdgeOut !== 4'b1000) begin errors++; $display("FAIL coll_same_cycle_sof: got n=%0d edge=%b expected 3/1000", coll_seen - c0, bus.hitEdgeOut); end
  endtask

  task automatic test_ceiling();
    t0 = tog_seen;
    bus.topLeftY = 11'sd10;  repeat (5) cyc();
    bus.topLeftY = 11'sd100; repeat (3) cyc();
    bus.topLeftY = 11'sd12;  repeat (3) cyc();
    bus.topLeftY = 11'sd100; repeat (3) cyc();
    checks++; if (tog_seen - t0 !== 2) begin errors++; $display("FAIL toggle_two: got %0d expected 2", tog_seen - t0); end
    bus.topLeftY = 11'sd17;  repeat (3) cyc();
    bus.topLeftY = 11'sd16;  repeat (3) cyc();
    bus.topLeftY = 11'sd100; repeat (3) cyc();
    bus.topLeftY = -11'sd5;  repeat (3) cyc();
    bus.topLeftY = 11'sd100; repeat (3) cyc();
    checks++; if (tog_seen - t0 !== 4 || state !== 3'd2) begin errors++; $display("FAIL toggle_bounds: got n=%0d state=%0d expected 4/2", tog_seen - t0, state); end
  endtask

  task automatic test_pause();
    pauseKey = 1'b1; cyc();
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL pause_entry: got %0d expected 3", state); end
    t0 = tick_seen; c0 = coll_seen; t0 = t0 + tog_seen;
    bus.collision = 1'b1; startKey = 1'b1;
    frame(10);
    bus.collision = 1'b0; startKey = 1'b0; cyc();
    checks++; if (state !== 3'd3 || tick_seen + tog_seen !== t0 || coll_seen !== c0) begin
      errors++; $display("FAIL pause_hold: got state=%0d pulses=%0d coll=%0d expected 3/%0d/%0d", state, tick_seen + tog_seen, coll_seen, t0, c0);
    end
    pauseKey = 1'b0; cyc(); pauseKey = 1'b1; cyc();
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL pause_exit: got %0d expected 2", state); end
    pauseKey = 1'b0; cyc();
    pauseKey = 1'b1; bus.topLeftY = 11'sd445; cyc();
    pauseKey = 1'b0; bus.topLeftY = 11'sd100;
    checks++; if (state !== 3'd4 || lives !== 3'd2) begin errors++; $display("FAIL floor_over_pause: got state=%0d lives=%0d expected 4/2", state, lives); end
  endtask

  task automatic test_loss_and_async_reset();
    t0 = tick_seen;
    frame(59);
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL lost_59: got %0d expected 4", state); end
    frame(1);
    checks++; if (state !== 3'd1 || lives !== 3'd2 || bus.moverRestartN !== 1'b0 || tick_seen !== t0) begin
      errors++; $display("FAIL lost_to_serve: got state=%0d lives=%0d rst=%b ticks=%0d expected 1/2/0/%0d", state, lives, bus.moverRestartN, tick_seen, t0);
    end
    frame(30);
    bus.topLeftY = 11'sd445; cyc(); bus.topLeftY = 11'sd100;
    checks++; if (state !== 3'd4 || lives !== 3'd1) begin errors++; $display("FAIL second_loss: got state=%0d lives=%0d expected 4/1", state, lives); end
    frame(5);
    resetN = 1'b0; #2;
    checks++; if (state !== 3'd0 || lives !== 3'd3 || gameOver !== 1'b0 || bus.moverRestartN !== 1'b0 || bus.hitEdgeOut !== 4'd0) begin
      errors++; $display("FAIL async_reset: got state=%0d lives=%0d go=%b rst=%b edge=%b expected 0/3/0/0/0000", state, lives, gameOver, bus.moverRestartN, bus.hitEdgeOut);
    end
    cyc(); resetN = 1'b1; cyc();
  endtask

  task automatic test_game_over();
    startKey = 1'b1; cyc(); startKey = 1'b0;
    frame(30);
    for (int i = 0; i < 3; i++) begin
      bus.topLeftY = (i == 1) ? 11'sd440 : 11'sd445; cyc(); bus.topLeftY = 11'sd100;
      checks++; if (lives !== 3'(2 - i)) begin errors++; $display("FAIL loss_%0d_lives: got %0d expected %0d", i, lives, 2 - i); end
      frame(60);
      if (i < 2) begin
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL loss_%0d_serve: got %0d expected 1", i, state); end
        frame(30);
      end else begin
        checks++; if (state !== 3'd5 || gameOver !== 1'b1 || lives !== 3'd0) begin
          errors++; $display("FAIL game_over: got state=%0d go=%b lives=%0d expected 5/1/0", state, gameOver, lives);
        end
      end
    end
    startKey = 1'b1; cyc(); startKey = 1'b0;
    checks++; if (state !== 3'd1 || lives !== 3'd3 || gameOver !== 1'b0) begin
      errors++; $display("FAIL restart: got state=%0d lives=%0d go=%b expected 1/3/0", state, lives, gameOver);
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_collision();
    test_ceiling();
    test_pause();
    test_loss_and_async_reset();
    test_game_over();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
